// File: rtl/tick_sched_if.sv
// Configuration handshake bundle for tick_sched: request fields plus ready/err responses.
interface tick_sched_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned PW  = 16
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic           cfg_en;
    logic           cfg_oneshot;
    logic [PW-1:0]  cfg_period;
    logic           cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_en, cfg_oneshot, cfg_period,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_en, cfg_oneshot, cfg_period,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: prescaled base tick drives per-channel periodic/one-shot countdowns.
// Optional remaining-count readback port enabled by defining TICK_SCHED_RDBK_EN.
module tick_sched #(
    parameter  int unsigned CLK_HZ  = 12_000_000,
    parameter  int unsigned BASE_HZ = 1000,
    parameter  int unsigned NCH     = 4,
    parameter  int unsigned PW      = 16,
    localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tick_sched_if.slave    cfg,
    output logic           base_tick,
    output logic [NCH-1:0] tick_o,
    output logic [NCH-1:0] active
`ifdef TICK_SCHED_RDBK_EN
    ,
    input  logic [CHW-1:0] rd_ch,
    output logic [PW-1:0]  rd_count
`endif
);
    localparam int unsigned DIV = CLK_HZ / BASE_HZ;
    localparam int unsigned PSW = $clog2(DIV);

    logic [PSW-1:0] psc_q;
    logic           psc_wrap;
    logic [PW-1:0]  cnt_q    [NCH];
    logic [PW-1:0]  cnt_d    [NCH];
    logic [PW-1:0]  period_q [NCH];
    logic [PW-1:0]  period_d [NCH];
    logic [NCH-1:0] active_d;
    logic [NCH-1:0] mode_q;
    logic [NCH-1:0] mode_d;
    logic [NCH-1:0] fire_d;
    logic           err_d;
    logic           xfer;
    logic           ch_ok;

    assign psc_wrap = (psc_q == PSW'(DIV - 1));
    assign xfer     = cfg.cfg_valid && cfg.cfg_ready;
    assign ch_ok    = (32'(cfg.cfg_ch) < NCH);

    // Countdown owns base_tick cycles; configuration can only land on the others since ready is low then.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        active_d = active;
        mode_d   = mode_q;
        fire_d   = '0;
        err_d    = 1'b0;
        if (base_tick) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (active[i]) begin
                    if (cnt_q[i] == PW'(1)) begin
                        fire_d[i] = 1'b1;
                        if (mode_q[i]) begin
                            active_d[i] = 1'b0;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i]    = period_q[i];
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - PW'(1);
                    end
                end
            end
        end else if (xfer) begin
            if (!ch_ok || (cfg.cfg_en && (cfg.cfg_period == '0))) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (CHW'(i) == cfg.cfg_ch) begin
                        if (cfg.cfg_en) begin
                            cnt_d[i]    = cfg.cfg_period;
                            period_d[i] = cfg.cfg_period;
                            mode_d[i]   = cfg.cfg_oneshot;
                            active_d[i] = 1'b1;
                        end else begin
                            cnt_d[i]    = '0;
                            active_d[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef TICK_SCHED_RDBK_EN
    logic [PW-1:0] rd_d;

    // Inactive channels already hold a zero count, but gate anyway so stale state never leaks.
    always_comb begin
        rd_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if ((CHW'(i) == rd_ch) && active[i]) begin
                rd_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else begin
            rd_count <= rd_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q         <= '0;
            base_tick     <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_err   <= 1'b0;
            tick_o        <= '0;
            active        <= '0;
            mode_q        <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            psc_q         <= psc_wrap ? '0 : psc_q + PSW'(1);
            base_tick     <= psc_wrap;
            cfg.cfg_ready <= !psc_wrap;
            cfg.cfg_err   <= err_d;
            tick_o        <= fire_d;
            active        <= active_d;
            mode_q        <= mode_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end
endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: directed scenarios plus random configuration traffic against
// a base-tick-deadline reference model. A second 3-channel instance exercises out-of-range channels.
module tb_tick_sched;
    localparam int unsigned DIV = 12;
    localparam int unsigned NCH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tick_sched_if #(.NCH(4), .PW(16)) cif ();
    tick_sched_if #(.NCH(3), .PW(16)) cif3 ();

    logic       base_tick, base3;
    logic [3:0] tick_o, active;
    logic [2:0] tick3, active3;
`ifdef TICK_SCHED_RDBK_EN
    logic [1:0]  rd_ch, rd_ch3;
    logic [15:0] rd_count, rd_count3;
`endif

    tick_sched #(.CLK_HZ(12000), .BASE_HZ(1000), .NCH(4), .PW(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cif.slave),
        .base_tick(base_tick), .tick_o(tick_o), .active(active)
`ifdef TICK_SCHED_RDBK_EN
        , .rd_ch(rd_ch), .rd_count(rd_count)
`endif
    );

    tick_sched #(.CLK_HZ(12000), .BASE_HZ(1000), .NCH(3), .PW(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg(cif3.slave),
        .base_tick(base3), .tick_o(tick3), .active(active3)
`ifdef TICK_SCHED_RDBK_EN
        , .rd_ch(rd_ch3), .rd_count(rd_count3)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: channels track the absolute base-tick index of their next fire.
    int         n;
    int         base_cnt;
    int         tgt [4];
    int         per [4];
    logic [3:0] act, one;
    logic       e_base, e_ready, e_err, e_err3;
    logic [3:0] e_tick;
    logic [15:0] e_rd;
    logic       last_xfer, last_xfer3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; base_cnt = 0; act = '0; one = '0;
        e_base = 0; e_ready = 0; e_err = 0; e_err3 = 0; e_tick = '0; e_rd = '0;
        last_xfer = 0; last_xfer3 = 0;
        for (int c = 0; c < 4; c++) begin tgt[c] = 0; per[c] = 0; end
    endtask

    task automatic step();
        logic pb, pr, xf, xf3;
        logic [15:0] rd_pre;
        int ch;
        pb = e_base; pr = e_ready;
        xf  = cif.cfg_valid && pr;
        xf3 = cif3.cfg_valid && pr;
        rd_pre = '0;
`ifdef TICK_SCHED_RDBK_EN
        if (act[rd_ch]) rd_pre = 16'(tgt[rd_ch] - base_cnt);
`endif
        @(posedge clk); #1;
        n++;
        e_base = (n % DIV == 0);
        e_ready = !e_base;
        e_err = 0; e_err3 = 0; e_tick = '0; e_rd = rd_pre;
        last_xfer = xf; last_xfer3 = xf3;
        if (pb) begin
            base_cnt++;
            for (int c = 0; c < 4; c++) begin
                if (act[c] && tgt[c] == base_cnt) begin
                    e_tick[c] = 1'b1;
                    if (one[c]) act[c] = 1'b0;
                    else tgt[c] += per[c];
                end
            end
        end else if (xf) begin
            ch = int'(cif.cfg_ch);
            if (ch >= NCH || (cif.cfg_en && cif.cfg_period == 0)) e_err = 1'b1;
            else if (cif.cfg_en) begin
                act[ch] = 1'b1; one[ch] = cif.cfg_oneshot;
                per[ch] = int'(cif.cfg_period); tgt[ch] = base_cnt + per[ch];
            end else act[ch] = 1'b0;
        end
        if (xf3) e_err3 = (int'(cif3.cfg_ch) >= 3) || (cif3.cfg_en && cif3.cfg_period == 0);
        chk("base_tick", 32'(base_tick), 32'(e_base));
        chk("cfg_ready", 32'(cif.cfg_ready), 32'(e_ready));
        chk("cfg_err", 32'(cif.cfg_err), 32'(e_err));
        chk("tick_o", 32'(tick_o), 32'(e_tick));
        chk("active", 32'(active), 32'(act));
        chk("base_tick3", 32'(base3), 32'(e_base));
        chk("cfg_err3", 32'(cif3.cfg_err), 32'(e_err3));
        chk("active3", 32'(active3), 32'(0));
        chk("tick3", 32'(tick3), 32'(0));
`ifdef TICK_SCHED_RDBK_EN
        chk("rd_count", 32'(rd_count), 32'(e_rd));
`endif
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic cfg(input int ch, input int en, input int os, input int pv);
        int k;
        cif.cfg_valid = 1'b1; cif.cfg_ch = 2'(ch); cif.cfg_en = 1'(en);
        cif.cfg_oneshot = 1'(os); cif.cfg_period = 16'(pv);
        k = 0;
        do begin step(); k++; end while (!last_xfer && k < 4);
        if (!last_xfer) begin
            checks++; errors++;
            $error("FAIL cfg_timeout observed=%0d expected=accept", k);
        end
        cif.cfg_valid = 1'b0;
    endtask

    task automatic cfg3(input int ch, input int en, input int pv);
        int k;
        cif3.cfg_valid = 1'b1; cif3.cfg_ch = 2'(ch); cif3.cfg_en = 1'(en);
        cif3.cfg_oneshot = 1'b0; cif3.cfg_period = 16'(pv);
        k = 0;
        do begin step(); k++; end while (!last_xfer3 && k < 4);
        if (!last_xfer3) begin
            checks++; errors++;
            $error("FAIL cfg3_timeout observed=%0d expected=accept", k);
        end
        cif3.cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_base_tick", 32'(base_tick), 32'(0));
        chk("rst_cfg_ready", 32'(cif.cfg_ready), 32'(0));
        chk("rst_cfg_err", 32'(cif.cfg_err), 32'(0));
        chk("rst_tick_o", 32'(tick_o), 32'(0));
        chk("rst_active", 32'(active), 32'(0));
`ifdef TICK_SCHED_RDBK_EN
        chk("rst_rd_count", 32'(rd_count), 32'(0));
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        cif.cfg_valid = 0; cif.cfg_ch = '0; cif.cfg_en = 0; cif.cfg_oneshot = 0; cif.cfg_period = '0;
        cif3.cfg_valid = 0; cif3.cfg_ch = '0; cif3.cfg_en = 0; cif3.cfg_oneshot = 0; cif3.cfg_period = '0;
`ifdef TICK_SCHED_RDBK_EN
        rd_ch = 2'd0; rd_ch3 = 2'd0;
`endif
        model_reset();
        do_reset();

        // Free-running base tick, nothing configured.
        idle(40);

        // Periodic ch0 period 3, then one-shot ch1 period 2.
        cfg(0, 1, 0, 3);
        idle(80);
        cfg(1, 1, 1, 2);
        idle(40);

        // Rejections: zero period, out-of-range channel on the 3-channel instance.
        cfg(2, 1, 0, 0);
        idle(3);
        cfg3(3, 1, 5);
        idle(2);
        cfg3(3, 0, 0);
        idle(2);

        // Request held across a base_tick cycle is taken on the following cycle.
        while (n % DIV != 0) step();
        cfg(2, 1, 1, 1);
        idle(20);

        // Two channels loaded in the same base interval fire together; then stop ch3.
        while (n % DIV != 1) step();
        cfg(0, 1, 0, 4);
        cfg(3, 1, 0, 4);
        idle(60);
        cfg(3, 0, 0, 0);
        idle(60);

        // Reset mid-count abandons all channels.
        cfg(0, 1, 0, 3);
        idle(50);
        do_reset();
        idle(40);

        // Random configuration traffic, including stops, restarts and rejected zero periods.
        for (int it = 0; it < 40; it++) begin
`ifdef TICK_SCHED_RDBK_EN
            rd_ch = 2'($urandom_range(0, 3));
`endif
            cfg(int'($urandom_range(0, 3)), ($urandom % 4) != 0 ? 1 : 0,
                int'($urandom % 2), int'($urandom_range(0, 5)));
            idle(int'($urandom_range(0, 30)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
